// File: rtl/uart_console_pkg.sv
// Shared types and constants for the UART console: FSM states, ASCII command
// codes, active-low RGB encodings and the built-in banner text.
package uart_console_pkg;

  typedef enum logic [2:0] {S_FETCH, S_BANNER, S_IDLE, S_ECHO, S_LF} state_t;

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_G  = 8'h47;
  localparam logic [7:0] CHAR_B  = 8'h42;
  localparam logic [7:0] CHAR_X  = 8'h58;
  localparam logic [7:0] CHAR_H  = 8'h48;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  // Clearing bit 5 folds lower-case letters onto upper-case
  localparam logic [7:0] CASE_MASK = 8'hDF;

  localparam logic [2:0] RGB_OFF = 3'b111;
  localparam logic [2:0] RGB_R   = 3'b011;
  localparam logic [2:0] RGB_G   = 3'b101;
  localparam logic [2:0] RGB_B   = 3'b110;

  // "Hello World!\n"
  function automatic logic [7:0] banner_byte(input int unsigned idx);
    case (idx)
      0: return 8'h48;  1: return 8'h65;  2: return 8'h6C;  3: return 8'h6C;
      4: return 8'h6F;  5: return 8'h20;  6: return 8'h57;  7: return 8'h6F;
      8: return 8'h72;  9: return 8'h6C; 10: return 8'h64; 11: return 8'h21;
      12: return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_console_if.sv
// Byte handshake between uart_driver (master) and the console (slave).
interface uart_console_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, output rx_valid, output tx_ready,
                  input  tx_data, input  tx_valid);
  modport slave  (input  rx_data, input  rx_valid, input  tx_ready,
                  output tx_data, output tx_valid);
endinterface

// File: rtl/block_rom.sv
// Single-port ROM with one cycle of read latency holding the banner text.
module block_rom
  import uart_console_pkg::*;
#(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);
  always_ff @(posedge clk)
    data <= (32'(addr) < DEPTH) ? banner_byte(32'(addr)) : 8'h00;
endmodule

// File: rtl/edge_detector.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk)
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= sig;
      rise <= sig & ~prev;
    end
endmodule

// File: rtl/uart_console_fifo.sv
// Synchronous 8-bit byte FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 wdata,
  input  logic                       pop,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this same cycle, so push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;

  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/uart_console.sv
// Banner-then-echo UART console with RGB commands and buffered RX.
// Define UART_CONSOLE_CRLF_EN to follow each echoed CR with an LF.
module uart_console
  import uart_console_pkg::*;
#(
  parameter int BANNER_L   = 13,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  uart_console_if.slave                   bus,
  output logic [2:0]                      rgb,
  output logic                            banner_done,
  output logic                            overflow,
  output logic [CNT_W-1:0]                drop_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int RA_W = (BANNER_L > 1) ? $clog2(BANNER_L) : 1;
  localparam logic [RA_W-1:0] LAST = RA_W'(BANNER_L - 1);

  state_t state, state_nxt;
  logic [RA_W-1:0] rom_addr, addr_nxt;
  logic [7:0] rom_data, cmd, cmd_nxt, rx_data_q, head;
  logic [2:0] rgb_nxt;
  logic done_nxt, rx_rise, pop, full, empty, tx_valid;
  logic [7:0] tx_data;

  edge_detector u_edge (.clk(clk), .rst(rst), .sig(bus.rx_valid), .rise(rx_rise));

  // Data is registered alongside the edge pulse so the two stay aligned
  always_ff @(posedge clk)
    if (rst) rx_data_q <= '0;
    else     rx_data_q <= bus.rx_data;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(rx_rise), .wdata(rx_data_q), .pop(pop),
    .rdata(head), .full(full), .empty(empty), .level(fifo_level)
  );

  block_rom #(.DEPTH(BANNER_L), .AW(RA_W)) u_rom (
    .clk(clk), .addr(rom_addr), .data(rom_data)
  );

  always_ff @(posedge clk)
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (rx_rise && full && !pop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end

  always_ff @(posedge clk)
    if (rst) begin
      state       <= S_FETCH;
      rom_addr    <= '0;
      banner_done <= 1'b0;
      rgb         <= RGB_OFF;
      cmd         <= '0;
    end else begin
      state       <= state_nxt;
      rom_addr    <= addr_nxt;
      banner_done <= done_nxt;
      rgb         <= rgb_nxt;
      cmd         <= cmd_nxt;
    end

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    done_nxt  = banner_done;
    rgb_nxt   = rgb;
    cmd_nxt   = cmd;
    pop       = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state)
      S_FETCH: state_nxt = S_BANNER;
      S_BANNER: begin
        tx_valid = 1'b1;
        tx_data  = rom_data;
        if (bus.tx_ready) begin
          if (rom_addr == LAST) begin
            addr_nxt  = '0;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            addr_nxt  = rom_addr + 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_IDLE:
        if (!empty) begin
          pop       = 1'b1;
          cmd_nxt   = head;
          state_nxt = S_ECHO;
        end
      S_ECHO: begin
        tx_valid = 1'b1;
        tx_data  = cmd;
        if (bus.tx_ready) begin
          state_nxt = S_IDLE;
          case (cmd & CASE_MASK)
            CHAR_R: rgb_nxt = RGB_R;
            CHAR_G: rgb_nxt = RGB_G;
            CHAR_B: rgb_nxt = RGB_B;
            CHAR_X: rgb_nxt = RGB_OFF;
            CHAR_H: begin
              done_nxt  = 1'b0;
              state_nxt = S_FETCH;
            end
            default: ;
          endcase
`ifdef UART_CONSOLE_CRLF_EN
          if (cmd == CHAR_CR) state_nxt = S_LF;
`endif
        end
      end
`ifdef UART_CONSOLE_CRLF_EN
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = CHAR_LF;
        if (bus.tx_ready) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data;
endmodule
